// File: rtl/cordic_ctrl.sv
// Sequencer for the iterative CORDIC datapath: start-edge detection, operand snapshot,
// ITERS micro-rotation drive, result capture, and bus-readable status/results.
module cordic_ctrl #(
    parameter int ITERS = 16,
    parameter int IW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [31:0]   x_in,
    input  logic [31:0]   y_in,
    input  logic [31:0]   z_in,
    output logic          core_load,
    output logic          core_en,
    output logic [IW-1:0] core_iter,
    output logic [31:0]   core_x0,
    output logic [31:0]   core_y0,
    output logic [31:0]   core_z0,
    input  logic [31:0]   core_x,
    input  logic [31:0]   core_y,
    input  logic [31:0]   core_z,
    input  logic [5:0]    bus_addr,
    input  logic          bus_rd,
    output logic [31:0]   bus_data_out,
    output logic          busy,
    output logic          done,
    output logic          irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [IW-1:0] LAST_ITER = IW'(ITERS - 1);

    state_t        state;
    state_t        state_nx;
    logic          start_q;
    logic          start_edge;
    logic          start_op;
    logic          done_set;
    logic          overrun_set;
    logic          status_rd;
    logic          overrun;
    logic [IW-1:0] cnt;
    logic [31:0]   res_x;
    logic [31:0]   res_y;
    logic [31:0]   res_z;

    assign start_edge  = start & ~start_q;
    assign start_op    = start_edge & ((state == S_IDLE) | (state == S_DONE));
    assign done_set    = (state == S_CAPTURE);
    assign overrun_set = start_edge & busy;
    assign status_rd   = bus_rd & (bus_addr == 6'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        core_load = 1'b0;
        core_en   = 1'b0;
        core_iter = '0;
        busy      = 1'b0;
        case (state)
            S_IDLE, S_DONE: if (start_edge) state_nx = S_LOAD;
            S_LOAD: begin
                core_load = 1'b1;
                busy      = 1'b1;
                state_nx  = S_ITER;
            end
            S_ITER: begin
                core_en   = 1'b1;
                core_iter = cnt;
                busy      = 1'b1;
                if (cnt == LAST_ITER) state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy     = 1'b1;
                state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            cnt          <= '0;
            core_x0      <= '0;
            core_y0      <= '0;
            core_z0      <= '0;
            res_x        <= '0;
            res_y        <= '0;
            res_z        <= '0;
            done         <= 1'b0;
            irq          <= 1'b0;
            overrun      <= 1'b0;
            bus_data_out <= '0;
        end else begin
            start_q <= start;
            irq     <= done_set;

            if (start_op) begin
                core_x0 <= x_in;
                core_y0 <= y_in;
                core_z0 <= z_in;
            end

            if (state == S_LOAD)      cnt <= '0;
            else if (state == S_ITER) cnt <= (cnt == LAST_ITER) ? '0 : cnt + 1'b1;

            if (state == S_CAPTURE) begin
                res_x <= core_x;
                res_y <= core_y;
                res_z <= core_z;
            end

            // A set in the same cycle as a read-clear takes priority.
            if (done_set)                    done <= 1'b1;
            else if (status_rd || start_op)  done <= 1'b0;

            if (overrun_set)    overrun <= 1'b1;
            else if (status_rd) overrun <= 1'b0;

            if (bus_rd) begin
                case (bus_addr)
                    6'd4:    bus_data_out <= {29'b0, overrun, done, busy};
                    6'd5:    bus_data_out <= res_x;
                    6'd6:    bus_data_out <= res_y;
                    6'd7:    bus_data_out <= res_z;
                    default: bus_data_out <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cordic_ctrl.sv
// Directed self-checking bench for cordic_ctrl with a constant-output stub core.
module tb_cordic_ctrl;

    localparam int ITERS = 16;
    localparam int IW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   x_in, y_in, z_in;
    logic          core_load, core_en;
    logic [IW-1:0] core_iter;
    logic [31:0]   core_x0, core_y0, core_z0;
    logic [31:0]   core_x, core_y, core_z;
    logic [5:0]    bus_addr;
    logic          bus_rd;
    logic [31:0]   bus_data_out;
    logic          busy, done, irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign core_x = 32'h1111_1111;
    assign core_y = 32'h2222_2222;
    assign core_z = 32'h3333_3333;

    cordic_ctrl #(.ITERS(ITERS), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .core_load(core_load), .core_en(core_en), .core_iter(core_iter),
        .core_x0(core_x0), .core_y0(core_y0), .core_z0(core_z0),
        .core_x(core_x), .core_y(core_y), .core_z(core_z),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_data_out(bus_data_out),
        .busy(busy), .done(done), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [5:0] addr, output logic [31:0] data);
        bus_addr = addr;
        bus_rd   = 1'b1;
        tick();
        bus_rd   = 1'b0;
        data     = bus_data_out;
    endtask

    task automatic wait_done(input int max_cycles, output int n);
        n = 0;
        while (!done && n < max_cycles) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int          n;
        bit          seen_busy;

        rst_n = 1'b0; start = 1'b0; bus_rd = 1'b0; bus_addr = '0;
        x_in = '0; y_in = '0; z_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bus", bus_data_out, 0);
        rst_n = 1'b1;
        tick();

        // 1: reset in the middle of ITER
        x_in = 32'h1234_5678;
        start = 1'b1;
        tick();
        repeat (8) tick();
        check("t1_iter7", 32'(core_iter), 7);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t1_busy", 32'(busy), 0);
        check("t1_core_en", 32'(core_en), 0);
        check("t1_done", 32'(done), 0);
        check("t1_core_x0", core_x0, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("t1_idle_busy", 32'(busy), 0);
        rd(6'd5, d); check("t1_res_x", d, 0);
        rd(6'd7, d); check("t1_res_z", d, 0);
        rd(6'd4, d); check("t1_status", d, 0);

        // 2: basic operation with latency checks
        x_in = 32'hAAAA_0001; y_in = 32'h5555_0002; z_in = 32'h0F0F_0003;
        start = 1'b1;
        check("t2_no_load_yet", 32'(core_load), 0);
        tick();
        check("t2_load", 32'(core_load), 1);
        check("t2_load_en", 32'(core_en), 0);
        check("t2_load_busy", 32'(busy), 1);
        check("t2_x0", core_x0, 32'hAAAA_0001);
        check("t2_y0", core_y0, 32'h5555_0002);
        check("t2_z0", core_z0, 32'h0F0F_0003);
        for (int i = 0; i < ITERS; i++) begin
            tick();
            check($sformatf("t2_en%0d", i), 32'(core_en), 1);
            check($sformatf("t2_iter%0d", i), 32'(core_iter), 32'(i));
        end
        tick();
        check("t2_cap_en", 32'(core_en), 0);
        check("t2_cap_iter", 32'(core_iter), 0);
        check("t2_cap_busy", 32'(busy), 1);
        check("t2_cap_done", 32'(done), 0);
        tick();
        check("t2_done", 32'(done), 1);
        check("t2_irq", 32'(irq), 1);
        check("t2_done_busy", 32'(busy), 0);
        tick();
        check("t2_irq_pulse", 32'(irq), 0);
        check("t2_done_sticky", 32'(done), 1);
        rd(6'd5, d); check("t2_res_x", d, 32'h1111_1111);
        rd(6'd6, d); check("t2_res_y", d, 32'h2222_2222);
        tick();
        check("t2_bus_hold", bus_data_out, 32'h2222_2222);
        rd(6'd7, d); check("t2_res_z", d, 32'h3333_3333);
        rd(6'd3, d); check("t2_addr3", d, 0);

        // 3: operand snapshot; the new edge from DONE also clears done
        start = 1'b0;
        tick();
        x_in = 32'h0001_0000;
        start = 1'b1;
        tick();
        check("t3_load", 32'(core_load), 1);
        check("t3_done_clr", 32'(done), 0);
        repeat (4) tick();
        x_in = 32'hFFFF_0000;
        repeat (4) tick();
        check("t3_iter_en", 32'(core_en), 1);
        check("t3_x0_held", core_x0, 32'h0001_0000);
        repeat (10) tick();
        check("t3_done", 32'(done), 1);

        // 4: overrun while busy
        start = 1'b0;
        tick();
        x_in = 32'h0000_4444;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t4_iter3", 32'(core_iter), 3);
        x_in = 32'hDEAD_BEEF;
        start = 1'b1;
        tick();
        check("t4_no_restart", 32'(core_load), 0);
        check("t4_busy", 32'(busy), 1);
        check("t4_x0", core_x0, 32'h0000_4444);
        repeat (12) tick();
        check("t4_cap_done", 32'(done), 0);
        tick();
        check("t4_done", 32'(done), 1);
        check("t4_irq", 32'(irq), 1);
        rd(6'd4, d); check("t4_status", d, 32'h6);
        rd(6'd4, d); check("t4_status_clr", d, 32'h0);

        // 5: status read coinciding with DONE entry
        start = 1'b0;
        tick();
        start = 1'b1;
        repeat (18) tick();
        check("t5_capture", 32'(busy), 1);
        bus_addr = 6'd4;
        bus_rd   = 1'b1;
        tick();
        bus_rd   = 1'b0;
        check("t5_race_data", bus_data_out, 32'h1);
        check("t5_done_wins", 32'(done), 1);
        rd(6'd4, d); check("t5_status", d, 32'h2);
        rd(6'd4, d); check("t5_status_clr", d, 32'h0);

        // 6: level hold does not retrigger; a fresh toggle does
        start = 1'b0;
        tick();
        start = 1'b1;
        wait_done(40, n);
        check("t6_latency", 32'(n), 32'(ITERS + 3));
        seen_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || core_load) seen_busy = 1'b1;
        end
        check("t6_no_second_op", 32'(seen_busy), 0);
        check("t6_done_held", 32'(done), 1);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("t6_restart_load", 32'(core_load), 1);
        check("t6_restart_done", 32'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
